bus_sys_pixel_write_master: RTL and testbench

BUS_SYS_PIXEL_WRITE_MASTER -- requirements
Module: bus_sys_pixel_write_master

---
 rtl/bus_sys_pix_pkg.sv | 16 +
 rtl/bus_sys_pixel_write_master_if.sv | 30 +++
 rtl/bus_sys_pixel_write_master.sv | 122 ++++++++++++
 tb/tb_bus_sys_pixel_write_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sys_pix_pkg.sv
// Shared definitions for the pixel write master: FSM states, pixel/word
// widths and the default frame size (320x240 RGB565, two pixels per word).
package bus_sys_pix_pkg;

    localparam int unsigned PIX_W         = 16;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned NUM_WORDS_DEF = 38400;

    typedef enum logic [1:0] {
        SYNC,
        PIX0,
        PIX1,
        WR
    } state_e;

endpackage

// File: rtl/bus_sys_pixel_write_master_if.sv
// Pixel stream sink plus memory write bus. The master modport is the DUT's
// view of both; the slave modport is the view of the source/memory side.
interface bus_sys_pixel_write_master_if
    import bus_sys_pix_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
);

    logic              s_valid;
    logic [PIX_W-1:0]  s_data;
    logic              s_sof;
    logic              s_ready;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] writedata;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic              waitrequest;

    modport master (
        input  s_valid, s_data, s_sof, waitrequest,
        output s_ready, address, writedata, byteenable, chipselect, write
    );

    modport slave (
        output s_valid, s_data, s_sof, waitrequest,
        input  s_ready, address, writedata, byteenable, chipselect, write
    );

endinterface

// File: rtl/bus_sys_pixel_write_master.sv
// Packs an RGB565 pixel stream into 32-bit pixel pairs and writes one frame
// per start-of-frame marker to consecutive word addresses.
module bus_sys_pixel_write_master
    import bus_sys_pix_pkg::*;
#(
    parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                en,
    bus_sys_pixel_write_master_if.master        bus,
    output logic                                clken,
    output logic                                frame_done,
    output logic                                frame_err
);

    localparam int unsigned     IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        rst_sync_q;
    logic              run;
    logic              ready;
    logic              take;
    logic              wr;

    // Reset asserts asynchronously but releases two edges later, so every
    // output (clken, s_ready included) leaves reset together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SYNC;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ready   = run && (state_q != WR);
        take    = ready && bus.s_valid;

        unique case (state_q)
            SYNC: begin
                if (take && bus.s_sof && en) begin
                    data_d[PIX_W-1:0] = bus.s_data;
                    idx_d             = '0;
                    state_d           = PIX1;
                end
            end
            PIX0, PIX1: begin
                if (take) begin
                    if (bus.s_sof) begin
                        // Early SOF: abandon the partial frame and restart on this pixel.
                        data_d[PIX_W-1:0] = bus.s_data;
                        idx_d             = '0;
                        err_d             = 1'b1;
                        state_d           = PIX1;
                    end else if (state_q == PIX0) begin
                        data_d[PIX_W-1:0] = bus.s_data;
                        state_d           = PIX1;
                    end else begin
                        data_d[WORD_W-1:PIX_W] = bus.s_data;
                        state_d                = WR;
                    end
                end
            end
            WR: begin
                if (!bus.waitrequest) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = SYNC;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = PIX0;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign wr = (state_q == WR);

    assign bus.s_ready    = ready;
    assign bus.write      = wr;
    assign bus.chipselect = wr;
    assign bus.byteenable = wr ? 4'hF : 4'h0;
    assign bus.address    = wr ? (ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q)) : '0;
    assign bus.writedata  = data_q;
    assign clken          = run;
    assign frame_done     = done_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_bus_sys_pixel_write_master.sv
// Directed bench for the pixel write master: a per-cycle vector table plus
// hand-written reset, full-frame, stall and early-SOF sequences.
module tb_bus_sys_pixel_write_master;

    localparam int unsigned NW    = 4;
    localparam int unsigned NROWS = 32;

    typedef struct {
        logic        en;
        logic        v;
        logic [15:0] d;
        logic        sof;
        logic        wq;
        logic        rdy;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        done;
        logic        err;
    } vec_t;

    logic clk;
    logic reset_n;
    logic en;
    logic clken;
    logic frame_done;
    logic frame_err;

    int unsigned n_cmp;
    int unsigned n_err;

    vec_t tbl [NROWS];

    bus_sys_pixel_write_master_if #(.ADDR_W(16)) bus ();

    bus_sys_pixel_write_master #(
        .NUM_WORDS (NW),
        .ADDR_W    (16),
        .BASE_ADDR (0)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .bus        (bus),
        .clken      (clken),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input int unsigned e, v, d, sof, wq,
                                input int unsigned rdy, wr, addr, wd, done, err);
        vec_t r;
        r.en   = 1'(e);
        r.v    = 1'(v);
        r.d    = 16'(d);
        r.sof  = 1'(sof);
        r.wq   = 1'(wq);
        r.rdy  = 1'(rdy);
        r.wr   = 1'(wr);
        r.addr = 16'(addr);
        r.wd   = wd;
        r.done = 1'(done);
        r.err  = 1'(err);
        return r;
    endfunction

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic e, input logic v, input logic [15:0] d,
                         input logic sof, input logic wq);
        @(negedge clk);
        en              = e;
        bus.s_valid     = v;
        bus.s_data      = d;
        bus.s_sof       = sof;
        bus.waitrequest = wq;
        #1;
    endtask

    task automatic chk_write(input string nm, input logic [15:0] addr, input logic [31:0] wd);
        chk_b({nm, " write"}, bus.write, 1'b1);
        chk_b({nm, " chipselect"}, bus.chipselect, 1'b1);
        chk_b({nm, " s_ready"}, bus.s_ready, 1'b0);
        chk_w({nm, " byteenable"}, 32'(bus.byteenable), 32'hF);
        chk_w({nm, " address"}, 32'(bus.address), 32'(addr));
        chk_w({nm, " writedata"}, bus.writedata, wd);
    endtask

    initial begin
        int unsigned writes;
        int unsigned dones;
        int unsigned taken;
        logic [15:0] lo;
        logic [15:0] hi;

        n_cmp           = 0;
        n_err           = 0;
        reset_n         = 1'b0;
        en              = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_sof       = 1'b0;
        bus.waitrequest = 1'b0;

        tbl[0]  = mk(1, 1, 'hAAAA, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 'hBBBB, 1, 0,  1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0,      0, 0,  1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 'h1111, 1, 0,  1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 'h2222, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0,      0, 0,  0, 1, 0, 'h2222_1111, 0, 0);
        tbl[6]  = mk(0, 1, 'h3333, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 'h4444, 0, 1,  1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0,      0, 1,  0, 1, 1, 'h4444_3333, 0, 0);
        tbl[9]  = mk(1, 1, 'h5555, 0, 1,  0, 1, 1, 'h4444_3333, 0, 0);
        tbl[10] = mk(1, 1, 'h5555, 0, 0,  0, 1, 1, 'h4444_3333, 0, 0);
        tbl[11] = mk(1, 1, 'h5555, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, 'h6666, 1, 0,  1, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 'h7777, 0, 0,  1, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 0, 0,      0, 0,  0, 1, 0, 'h7777_6666, 0, 0);
        tbl[15] = mk(1, 1, 'h8888, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 1, 'h9999, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0,      0, 0,  0, 1, 1, 'h9999_8888, 0, 0);
        tbl[18] = mk(1, 1, 'hAAAA, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 1, 'hBBBB, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 0, 0,      0, 0,  0, 1, 2, 'hBBBB_AAAA, 0, 0);
        tbl[21] = mk(1, 1, 'hCCCC, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[22] = mk(1, 1, 'hDDDD, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[23] = mk(1, 0, 0,      0, 0,  0, 1, 3, 'hDDDD_CCCC, 0, 0);
        tbl[24] = mk(1, 1, 'hEEEE, 0, 0,  1, 0, 0, 0, 1, 0);
        tbl[25] = mk(1, 0, 0,      0, 0,  1, 0, 0, 0, 0, 0);
        tbl[26] = mk(1, 1, 'h1234, 1, 0,  1, 0, 0, 0, 0, 0);
        tbl[27] = mk(1, 1, 'h5678, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[28] = mk(1, 0, 0,      0, 0,  0, 1, 0, 'h5678_1234, 0, 0);
        tbl[29] = mk(1, 1, 'hABCD, 1, 0,  1, 0, 0, 0, 0, 0);
        tbl[30] = mk(1, 1, 'h0F0F, 0, 0,  1, 0, 0, 0, 0, 1);
        tbl[31] = mk(1, 0, 0,      0, 0,  0, 1, 0, 'h0F0F_ABCD, 0, 0);

        // Reset values while reset_n is held low.
        #2;
        chk_b("rst s_ready", bus.s_ready, 1'b0);
        chk_b("rst write", bus.write, 1'b0);
        chk_b("rst chipselect", bus.chipselect, 1'b0);
        chk_w("rst byteenable", 32'(bus.byteenable), 32'h0);
        chk_w("rst address", 32'(bus.address), 32'h0);
        chk_w("rst writedata", bus.writedata, 32'h0);
        chk_b("rst clken", clken, 1'b0);
        chk_b("rst frame_done", frame_done, 1'b0);
        chk_b("rst frame_err", frame_err, 1'b0);

        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk_b("rel edge1 clken", clken, 1'b0);
        chk_b("rel edge1 s_ready", bus.s_ready, 1'b0);
        @(negedge clk);
        #1;
        chk_b("rel edge2 clken", clken, 1'b1);
        chk_b("rel edge2 s_ready", bus.s_ready, 1'b1);

        for (int unsigned i = 0; i < NROWS; i++) begin
            drive(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].sof, tbl[i].wq);
            chk_b($sformatf("row%0d s_ready", i), bus.s_ready, tbl[i].rdy);
            chk_b($sformatf("row%0d write", i), bus.write, tbl[i].wr);
            chk_b($sformatf("row%0d chipselect", i), bus.chipselect, tbl[i].wr);
            chk_w($sformatf("row%0d byteenable", i), 32'(bus.byteenable),
                  tbl[i].wr ? 32'hF : 32'h0);
            if (tbl[i].wr) begin
                chk_w($sformatf("row%0d address", i), 32'(bus.address), 32'(tbl[i].addr));
                chk_w($sformatf("row%0d writedata", i), bus.writedata, tbl[i].wd);
            end
            chk_b($sformatf("row%0d frame_done", i), frame_done, tbl[i].done);
            chk_b($sformatf("row%0d frame_err", i), frame_err, tbl[i].err);
        end

        // Reset in the middle of a stalled write (table leaves DUT in PIX0, index 1).
        drive(1, 1, 16'h1357, 0, 0);
        drive(1, 1, 16'h2468, 0, 0);
        drive(1, 0, 16'h0000, 0, 1);
        chk_write("midrst pre", 16'd1, 32'h2468_1357);
        #1;
        reset_n = 1'b0;
        #1;
        chk_b("midrst write", bus.write, 1'b0);
        chk_b("midrst chipselect", bus.chipselect, 1'b0);
        chk_b("midrst s_ready", bus.s_ready, 1'b0);
        chk_b("midrst clken", clken, 1'b0);
        chk_w("midrst writedata", bus.writedata, 32'h0);
        @(negedge clk);
        bus.waitrequest = 1'b0;
        reset_n         = 1'b1;
        @(negedge clk);
        #1;
        chk_b("midrst edge1 clken", clken, 1'b0);
        chk_b("midrst edge1 write", bus.write, 1'b0);
        @(negedge clk);
        #1;
        chk_b("midrst edge2 clken", clken, 1'b1);
        chk_b("midrst edge2 s_ready", bus.s_ready, 1'b1);
        writes = 0;
        for (int unsigned k = 0; k < 6; k++) begin
            drive(1, 1, 16'(16'h7000 + k), 0, 0);
            if (bus.write) writes++;
        end
        chk_w("nosof writes", writes, 32'd0);

        // Full frame of NW words starting from SYNC.
        dones  = 0;
        writes = 0;
        for (int unsigned w = 0; w < NW; w++) begin
            lo = 16'(16'hA000 + 2 * w);
            hi = 16'(16'hA001 + 2 * w);
            drive(1, 1, lo, (w == 0), 0);
            if (frame_done) dones++;
            drive(1, 1, hi, 0, 0);
            if (frame_done) dones++;
            drive(1, 0, 16'h0000, 0, 0);
            if (frame_done) dones++;
            if (bus.write) writes++;
            chk_write($sformatf("frame w%0d", w), 16'(w), {hi, lo});
        end
        chk_w("frame writes", writes, NW);
        chk_w("frame early dones", dones, 32'd0);
        drive(1, 0, 16'h0000, 0, 0);
        chk_b("frame_done pulse", frame_done, 1'b1);
        chk_b("frame_done s_ready", bus.s_ready, 1'b1);
        drive(1, 1, 16'h5A5A, 0, 0);
        chk_b("frame_done one cycle", frame_done, 1'b0);

        // Five stall cycles, then acceptance.
        drive(1, 1, 16'hC0DE, 1, 0);
        drive(1, 1, 16'hBEEF, 0, 0);
        taken = 0;
        for (int unsigned k = 0; k < 5; k++) begin
            drive(1, 1, 16'hDEAD, 0, 1);
            chk_write($sformatf("stall%0d", k), 16'd0, 32'hBEEF_C0DE);
            if (bus.write && !bus.waitrequest) taken++;
        end
        drive(1, 1, 16'hDEAD, 0, 0);
        chk_write("stall release", 16'd0, 32'hBEEF_C0DE);
        if (bus.write && !bus.waitrequest) taken++;
        chk_w("stall accepted writes", taken, 32'd1);

        // Continue the frame; SOF on the final pixel aborts instead of completing.
        for (int unsigned w = 1; w < NW - 1; w++) begin
            lo = 16'(16'h0101 * (2 * w - 1));
            hi = 16'(16'h0101 * (2 * w));
            drive(1, 1, lo, 0, 0);
            chk_b($sformatf("cont w%0d s_ready", w), bus.s_ready, 1'b1);
            drive(1, 1, hi, 0, 0);
            drive(1, 0, 16'h0000, 0, 0);
            chk_write($sformatf("cont w%0d", w), 16'(w), {hi, lo});
        end
        drive(1, 1, 16'h0505, 0, 0);
        drive(1, 1, 16'h0606, 1, 0);
        drive(1, 0, 16'h0000, 0, 0);
        chk_b("lastsof frame_err", frame_err, 1'b1);
        chk_b("lastsof frame_done", frame_done, 1'b0);
        chk_b("lastsof write", bus.write, 1'b0);
        drive(1, 1, 16'h0707, 0, 0);
        chk_b("lastsof err one cycle", frame_err, 1'b0);
        chk_b("lastsof no done", frame_done, 1'b0);
        drive(1, 0, 16'h0000, 0, 0);
        chk_write("lastsof restart", 16'd0, 32'h0707_0606);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
